// File: rtl/usb_tx_line_encoder.sv
// USB full-speed TX line encoder: LSB-first serialiser with bit stuffing, NRZI and EOP generation.
// All outputs are registered; line changes land one clk after the bit_strobe that sends the bit.
module usb_tx_line_encoder #(
  parameter int unsigned STUFF_LEN    = 6,
  parameter int unsigned EOP_SE0_BITS = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       bit_strobe,
  input  logic       enc_en,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       eop_en,
  output logic       d_plus,
  output logic       d_minus,
  output logic       byte_almost_complete,
  output logic       byte_complete,
  output logic       bit_stuff_en,
  output logic       eop_done,
  output logic       underrun
);

  localparam int unsigned Se0W = $clog2(EOP_SE0_BITS + 1);
  localparam logic [2:0]  StuffLast = 3'(STUFF_LEN - 1);
  localparam logic [2:0]  StuffMax  = 3'(STUFF_LEN);
  localparam logic [Se0W-1:0] Se0Last = Se0W'(EOP_SE0_BITS);

  typedef enum logic [2:0] {
    StIdle,
    StShift,
    StStuff,
    StEopSe0,
    StEopJ
  } state_e;

  state_e          state_q;
  logic [7:0]      shreg_q;
  logic [3:0]      bitcnt_q;
  logic [2:0]      onescnt_q;
  logic [Se0W-1:0] se0cnt_q;
  // NRZI line level: 1 = J, 0 = K.
  logic            nrzi_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q              <= StIdle;
      shreg_q              <= '0;
      bitcnt_q             <= '0;
      onescnt_q            <= '0;
      se0cnt_q             <= '0;
      nrzi_q               <= 1'b1;
      d_plus               <= 1'b1;
      d_minus              <= 1'b0;
      byte_almost_complete <= 1'b0;
      byte_complete        <= 1'b0;
      bit_stuff_en         <= 1'b0;
      eop_done             <= 1'b0;
      underrun             <= 1'b0;
    end else begin
      byte_almost_complete <= 1'b0;
      byte_complete        <= 1'b0;
      eop_done             <= 1'b0;
      underrun             <= 1'b0;

      if (!enc_en) begin
        state_q      <= StIdle;
        shreg_q      <= '0;
        bitcnt_q     <= '0;
        onescnt_q    <= '0;
        se0cnt_q     <= '0;
        nrzi_q       <= 1'b1;
        d_plus       <= 1'b1;
        d_minus      <= 1'b0;
        bit_stuff_en <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (load) begin
              shreg_q  <= load_data;
              bitcnt_q <= '0;
              state_q  <= StShift;
            end
          end

          StShift: begin
            if (bitcnt_q != 4'd8) begin
              if (bit_strobe) begin
                bit_stuff_en <= 1'b0;
                shreg_q      <= {1'b0, shreg_q[7:1]};
                bitcnt_q     <= bitcnt_q + 4'd1;
                if (shreg_q[0]) begin
                  if (onescnt_q != StuffMax) begin
                    onescnt_q <= onescnt_q + 3'd1;
                  end
                  if (onescnt_q == StuffLast) begin
                    state_q <= StStuff;
                  end
                end else begin
                  nrzi_q    <= ~nrzi_q;
                  d_plus    <= ~nrzi_q;
                  d_minus   <= nrzi_q;
                  onescnt_q <= '0;
                end
                if (bitcnt_q == 4'd6) begin
                  byte_almost_complete <= 1'b1;
                end
                if (bitcnt_q == 4'd7) begin
                  byte_complete <= 1'b1;
                end
              end
            end else if (eop_en) begin
              // eop_en outranks any load offered while the byte is drained.
              if (bit_strobe) begin
                bit_stuff_en <= 1'b0;
                se0cnt_q     <= Se0W'(1);
                d_plus       <= 1'b0;
                d_minus      <= 1'b0;
                state_q      <= StEopSe0;
              end
            end else if (load) begin
              shreg_q  <= load_data;
              bitcnt_q <= '0;
            end else if (bit_strobe) begin
              underrun     <= 1'b1;
              bit_stuff_en <= 1'b0;
              onescnt_q    <= '0;
              nrzi_q       <= 1'b1;
              d_plus       <= 1'b1;
              d_minus      <= 1'b0;
              bitcnt_q     <= '0;
              state_q      <= StIdle;
            end
          end

          StStuff: begin
            if (bit_strobe) begin
              nrzi_q       <= ~nrzi_q;
              d_plus       <= ~nrzi_q;
              d_minus      <= nrzi_q;
              onescnt_q    <= '0;
              bit_stuff_en <= 1'b1;
              state_q      <= StShift;
            end
          end

          StEopSe0: begin
            if (bit_strobe) begin
              if (se0cnt_q == Se0Last) begin
                se0cnt_q <= '0;
                d_plus   <= 1'b1;
                d_minus  <= 1'b0;
                state_q  <= StEopJ;
              end else begin
                se0cnt_q <= se0cnt_q + Se0W'(1);
              end
            end
          end

          StEopJ: begin
            if (bit_strobe) begin
              eop_done  <= 1'b1;
              nrzi_q    <= 1'b1;
              onescnt_q <= '0;
              bitcnt_q  <= '0;
              d_plus    <= 1'b1;
              d_minus   <= 1'b0;
              state_q   <= StIdle;
            end
          end

          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_tx_line_encoder.sv
// Directed bench for usb_tx_line_encoder: each strobe is checked against a hand-computed
// {line, almost, complete, stuff, eop_done, underrun} vector.
module tb_usb_tx_line_encoder;

  logic       clk;
  logic       n_rst;
  logic       bit_strobe;
  logic       enc_en;
  logic       load;
  logic [7:0] load_data;
  logic       eop_en;
  logic       d_plus;
  logic       d_minus;
  logic       byte_almost_complete;
  logic       byte_complete;
  logic       bit_stuff_en;
  logic       eop_done;
  logic       underrun;

  int total;
  int bad;

  localparam logic [1:0] J = 2'b10;
  localparam logic [1:0] K = 2'b01;
  localparam logic [1:0] S = 2'b00;
  localparam logic [4:0] N = 5'b00000;
  localparam logic [4:0] A = 5'b10000;
  localparam logic [4:0] C = 5'b01000;
  localparam logic [4:0] B = 5'b00100;
  localparam logic [4:0] E = 5'b00010;
  localparam logic [4:0] U = 5'b00001;

  usb_tx_line_encoder dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .bit_strobe           (bit_strobe),
    .enc_en               (enc_en),
    .load                 (load),
    .load_data            (load_data),
    .eop_en               (eop_en),
    .d_plus               (d_plus),
    .d_minus              (d_minus),
    .byte_almost_complete (byte_almost_complete),
    .byte_complete        (byte_complete),
    .bit_stuff_en         (bit_stuff_en),
    .eop_done             (eop_done),
    .underrun             (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] obs();
    return {d_plus, d_minus, byte_almost_complete, byte_complete, bit_stuff_en, eop_done,
            underrun};
  endfunction

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [7:0] d);
    load      = 1'b1;
    load_data = d;
    step();
    load      = 1'b0;
  endtask

  // One gap cycle, then a strobe; check right after the edge that consumed it.
  task automatic sb(input string tag, input logic [1:0] line, input logic [4:0] flags);
    step();
    bit_strobe = 1'b1;
    step();
    bit_strobe = 1'b0;
    check(tag, obs(), {line, flags});
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    n_rst      = 1'b0;
    bit_strobe = 1'b0;
    enc_en     = 1'b0;
    load       = 1'b0;
    load_data  = '0;
    eop_en     = 1'b0;
    #12;
    check("reset", obs(), {J, N});
    @(posedge clk);
    #1;
    n_rst  = 1'b1;
    enc_en = 1'b1;
    step();
    check("idle", obs(), {J, N});

    // Sync pattern 0x80.
    ld(8'h80);
    sb("sync1", K, N);
    sb("sync2", J, N);
    sb("sync3", K, N);
    sb("sync4", J, N);
    sb("sync5", K, N);
    sb("sync6", J, N);
    sb("sync7", K, A);
    sb("sync8", K, C);

    // No load after the byte: underrun and back to J.
    sb("underrun", J, U);

    // 0xFF from J: six holds, stuffed toggle, two more holds.
    ld(8'hFF);
    for (int i = 0; i < 6; i++) sb("ff_hold", J, N);
    sb("ff_stuff", K, B);
    sb("ff_b6", K, A);
    sb("ff_b7", K, C);

    // Back-to-back 0x0F: two carried ones plus four more force a stuff mid-byte.
    ld(8'h0F);
    sb("0f_b0", K, N);
    sb("0f_b1", K, N);
    sb("0f_b2", K, N);
    sb("0f_b3", K, N);
    sb("0f_stuff", J, B);
    sb("0f_b4", K, N);
    sb("0f_b5", J, N);
    sb("0f_b6", K, A);
    sb("0f_b7", J, C);

    // Back-to-back 0xFC ends with six ones: stuff must precede the EOP.
    ld(8'hFC);
    sb("fc_b0", K, N);
    sb("fc_b1", J, N);
    for (int i = 0; i < 4; i++) sb("fc_hold", J, N);
    sb("fc_b6", J, A);
    sb("fc_b7", J, C);
    eop_en = 1'b1;
    sb("fc_stuff", K, B);
    sb("eop_se0a", S, N);
    sb("eop_se0b", S, N);
    sb("eop_j", J, N);
    sb("eop_done", J, E);
    eop_en = 1'b0;
    sb("post_eop", J, N);

    // A load mid-byte is ignored; enc_en low aborts to J with no pulses.
    ld(8'h00);
    sb("ab_b0", K, N);
    ld(8'hFF);
    sb("ab_b1", J, N);
    sb("ab_b2", K, N);
    enc_en = 1'b0;
    step();
    check("abort_j", obs(), {J, N});
    for (int i = 0; i < 6; i++) sb("abort_quiet", J, N);
    enc_en = 1'b1;
    ld(8'h80);
    sb("reload_b0", K, N);

    // Async reset mid-shift: J immediately, then a fresh byte starts from J.
    #2;
    n_rst = 1'b0;
    #1;
    check("async_rst", obs(), {J, N});
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    step();
    ld(8'h80);
    sb("rst_b0", K, N);
    sb("rst_b1", J, N);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
